// File: rtl/decode_stage.sv
// decode_stage: pipelined RV32I decode between fetch and execute.
// Splits a fetched pc/instruction pair into opcode, register addresses,
// funct fields and a format-expanded immediate, flags illegal encodings and
// wfi, and presents the result one cycle after acceptance.
//
// Configuration macro: DECODE_SKID_EN
//   defined   - two-entry storage (output reg O + skid reg S), registered
//               in_ready = !S.valid, no out_ready -> in_ready path.
//   undefined - single output entry, in_ready = !O.valid || out_ready.
//
// Parameter: ZERO_UNUSED (default 1) - zero register-address fields the
//            instruction format does not use; 0 passes the raw bits.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous discard of all buffered entries
//   in_valid/in_ready   fetch-side handshake
//   in_pc, in_instr     fetched pc and raw instruction
//   out_valid/out_ready execute-side handshake
//   out_pc, out_instr   pass-through of the accepted pair
//   out_opcode, out_addr_rd/rs1/rs2, out_funct3, out_funct7, out_imm
//   out_illegal         unsupported or malformed encoding
//   out_wfi             instruction is exactly wfi
module decode_stage #(
  parameter bit ZERO_UNUSED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_addr_rd,
  output logic [4:0]  out_addr_rs1,
  output logic [4:0]  out_addr_rs2,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] out_imm,
  output logic        out_illegal,
  output logic        out_wfi
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;
  localparam int unsigned REGW = 5;

  localparam logic [OPW-1:0]  OP_LUI    = 7'h37;
  localparam logic [OPW-1:0]  OP_AUIPC  = 7'h17;
  localparam logic [OPW-1:0]  OP_ARITHI = 7'h13;
  localparam logic [OPW-1:0]  OP_JALR   = 7'h67;
  localparam logic [OPW-1:0]  OP_JAL    = 7'h6F;
  localparam logic [OPW-1:0]  OP_ARITHR = 7'h33;
  localparam logic [XLEN-1:0] WFI_INSTR = 32'h10500073;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            wfi;
  } entry_t;

  entry_t dec_c;
  logic   use_rd;
  logic   use_rs1;
  logic   use_rs2;
  logic   is_wfi;
  logic   illegal;

  // Combinational decode of the offered instruction.
  always_comb begin
    dec_c   = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    is_wfi  = (in_instr == WFI_INSTR);

    dec_c.pc     = in_pc;
    dec_c.instr  = in_instr;
    dec_c.opcode = in_instr[6:0];
    dec_c.funct3 = in_instr[14:12];
    dec_c.funct7 = in_instr[31:25];

    case (in_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        use_rd    = 1'b1;
        dec_c.imm = {in_instr[31:12], 12'b0};
      end
      OP_ARITHI: begin
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        dec_c.imm = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_JALR: begin
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        dec_c.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        illegal   = (in_instr[14:12] != 3'b000);
      end
      OP_JAL: begin
        use_rd    = 1'b1;
        dec_c.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_ARITHR: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = (in_instr[31:25] != 7'h00) && (in_instr[31:25] != 7'h20);
      end
      default: illegal = !is_wfi;
    endcase

    if (in_instr[1:0] != 2'b11) illegal = 1'b1;

    // wfi carries no register addresses regardless of ZERO_UNUSED.
    if (!is_wfi) begin
      dec_c.rd  = (use_rd  || !ZERO_UNUSED) ? in_instr[11:7]  : '0;
      dec_c.rs1 = (use_rs1 || !ZERO_UNUSED) ? in_instr[19:15] : '0;
      dec_c.rs2 = (use_rs2 || !ZERO_UNUSED) ? in_instr[24:20] : '0;
    end

    dec_c.illegal = illegal;
    dec_c.wfi     = is_wfi;
  end

  entry_t o_q;
  logic   o_valid_q;
  logic   accept;
  logic   consume;

  assign consume = o_valid_q && out_ready;

`ifdef DECODE_SKID_EN
  entry_t s_q;
  logic   s_valid_q;
  logic   in_ready_q;

  assign accept   = in_valid && in_ready_q;
  assign in_ready = in_ready_q;

  // Output + skid storage. in_ready_q tracks !s_valid_q one-for-one, so an
  // accept can never coincide with a full skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q        <= '0;
      s_q        <= '0;
      o_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      o_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (consume || !o_valid_q) begin
        if (s_valid_q) begin
          o_q       <= s_q;
          o_valid_q <= 1'b1;
        end else if (accept) begin
          o_q       <= dec_c;
          o_valid_q <= 1'b1;
        end else begin
          o_valid_q <= 1'b0;
        end
      end

      if (s_valid_q && consume) begin
        s_valid_q  <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (!s_valid_q && accept && o_valid_q && !consume) begin
        s_q        <= dec_c;
        s_valid_q  <= 1'b1;
        in_ready_q <= 1'b0;
      end
    end
  end
`else
  assign in_ready = !o_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Single output entry; ready is combinational from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else if (flush) begin
      o_valid_q <= 1'b0;
    end else if (accept) begin
      o_q       <= dec_c;
      o_valid_q <= 1'b1;
    end else if (consume) begin
      o_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid    = o_valid_q;
  assign out_pc       = o_q.pc;
  assign out_instr    = o_q.instr;
  assign out_opcode   = o_q.opcode;
  assign out_addr_rd  = o_q.rd;
  assign out_addr_rs1 = o_q.rs1;
  assign out_addr_rs2 = o_q.rs2;
  assign out_funct3   = o_q.funct3;
  assign out_funct7   = o_q.funct7;
  assign out_imm      = o_q.imm;
  assign out_illegal  = o_q.illegal;
  assign out_wfi      = o_q.wfi;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: hand-derived decode vectors, backpressure,
// flush and mid-transfer reset sequences, then randomized traffic checked
// against a queue-based reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_opcode;
  logic [4:0]  out_addr_rd;
  logic [4:0]  out_addr_rs1;
  logic [4:0]  out_addr_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic        out_wfi;

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_opcode   (out_opcode),
    .out_addr_rd  (out_addr_rd),
    .out_addr_rs1 (out_addr_rs1),
    .out_addr_rs2 (out_addr_rs2),
    .out_funct3   (out_funct3),
    .out_funct7   (out_funct7),
    .out_imm      (out_imm),
    .out_illegal  (out_illegal),
    .out_wfi      (out_wfi)
  );

  always #5 clk = ~clk;

`ifdef DECODE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic        wfi;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, " valid"},   32'(out_valid),    32'd1);
    chk({tag, " pc"},      out_pc,            e.pc);
    chk({tag, " instr"},   out_instr,         e.instr);
    chk({tag, " opcode"},  32'(out_opcode),   32'(e.opcode));
    chk({tag, " rd"},      32'(out_addr_rd),  32'(e.rd));
    chk({tag, " rs1"},     32'(out_addr_rs1), 32'(e.rs1));
    chk({tag, " rs2"},     32'(out_addr_rs2), 32'(e.rs2));
    chk({tag, " funct3"},  32'(out_funct3),   32'(e.instr[14:12]));
    chk({tag, " funct7"},  32'(out_funct7),   32'(e.instr[31:25]));
    chk({tag, " imm"},     out_imm,           e.imm);
    chk({tag, " illegal"}, 32'(out_illegal),  32'(e.illegal));
    chk({tag, " wfi"},     32'(out_wfi),      32'(e.wfi));
  endtask

  // Reference decode from the format rules, using plain arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    int   fmt;   // 0 none, 1 U, 2 I, 3 J, 4 R
    int   off;
    logic [6:0] op;
    op = instr[6:0];
    case (op)
      7'h37, 7'h17: fmt = 1;
      7'h13, 7'h67: fmt = 2;
      7'h6F:        fmt = 3;
      7'h33:        fmt = 4;
      default:      fmt = 0;
    endcase
    e.pc     = pc;
    e.instr  = instr;
    e.opcode = op;
    e.wfi    = (instr == 32'h10500073);
    case (fmt)
      1: e.imm = instr & 32'hFFFFF000;
      2: e.imm = 32'($signed(instr) >>> 20);
      3: begin
        off = int'(instr[30:21]) * 2 + int'(instr[20]) * 2048 + int'(instr[19:12]) * 4096;
        if (instr[31]) off = off - (1 << 20);
        e.imm = 32'(off);
      end
      default: e.imm = 32'd0;
    endcase
    e.rd  = (fmt != 0 && !e.wfi)           ? instr[11:7]  : 5'd0;
    e.rs1 = ((fmt == 2 || fmt == 4) && !e.wfi) ? instr[19:15] : 5'd0;
    e.rs2 = (fmt == 4 && !e.wfi)           ? instr[24:20] : 5'd0;
    e.illegal = (instr[1:0] != 2'b11) || (fmt == 0 && !e.wfi) ||
                (op == 7'h67 && instr[14:12] != 3'd0) ||
                (op == 7'h33 && instr[31:25] != 7'h00 && instr[31:25] != 7'h20);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  exp_t vec[10];
  exp_t q[$];

  initial begin
    // pc, instr, opcode, rd, rs1, rs2, imm, illegal, wfi
    vec[0] = '{32'h100, 32'h00500093, 7'h13, 5'd1, 5'd0, 5'd0, 32'h00000005, 1'b0, 1'b0};
    vec[1] = '{32'h104, 32'hFFF00113, 7'h13, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vec[2] = '{32'h108, 32'h123450B7, 7'h37, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0};
    vec[3] = '{32'h10C, 32'hFE1FF0EF, 7'h6F, 5'd1, 5'd0, 5'd0, 32'hFFFFFFE0, 1'b0, 1'b0};
    vec[4] = '{32'h110, 32'h10500073, 7'h73, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};
    vec[5] = '{32'h114, 32'h00000000, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vec[6] = '{32'h118, 32'h00001067, 7'h67, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vec[7] = '{32'h11C, 32'h02208033, 7'h33, 5'd0, 5'd1, 5'd2, 32'h00000000, 1'b1, 1'b0};
    vec[8] = '{32'h120, 32'h40208033, 7'h33, 5'd0, 5'd1, 5'd2, 32'h00000000, 1'b0, 1'b0};
    vec[9] = '{32'h124, 32'h00001117, 7'h17, 5'd2, 5'd0, 5'd0, 32'h00001000, 1'b0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset out_pc",    out_pc,         32'd0);
    chk("reset out_imm",   out_imm,        32'd0);
    chk("reset illegal",   32'(out_illegal), 32'd0);
    chk("reset wfi",       32'(out_wfi),     32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Table: one instruction per cycle with the sink always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = vec[i].pc; in_instr = vec[i].instr;
      tick();
      in_valid = 1'b0;
      check_out($sformatf("vec%0d", i), vec[i]);
    end
    tick();
    chk("drain out_valid", 32'(out_valid), 32'd0);

    // Backpressure: stall, see ready fall at capacity, then drain in order.
    begin
      int sent = 0, recv = 0;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
        out_ready = (cyc >= 6);
        in_valid  = (sent < 4);
        in_pc     = 32'h200 + 32'(sent) * 4;
        in_instr  = 32'h00000013 | (32'(sent + 1) << 7);
        #1;
        if (cyc == 5) begin
          chk("bp held count", 32'(sent), 32'(CAP));
          chk("bp in_ready",   32'(in_ready), 32'd0);
        end
        if (out_valid && out_ready) begin
          chk($sformatf("bp order %0d", recv), out_pc, 32'h200 + 32'(recv) * 4);
          recv++;
        end
        if (in_valid && in_ready) sent++;
        tick();
      end
      in_valid = 1'b0;
      chk("bp received", 32'(recv), 32'd4);
      tick();
      chk("bp no dup", 32'(out_valid), 32'd0);
    end

    // Flush with storage full and an input offered in the same cycle.
    begin
      int sent = 0;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 10 && sent < CAP; cyc++) begin
        in_valid = 1'b1; in_pc = 32'h500 + 32'(sent) * 4; in_instr = 32'h00100093;
        #1;
        if (in_ready) sent++;
        tick();
      end
      chk("flush prefill", 32'(sent), 32'(CAP));
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD0000;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("flush stays empty", 32'(out_valid), 32'd0);
      end
    end

    // Reset while an entry is held against backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'hFFF00113;
    tick();
    in_valid = 1'b0;
    chk("rst pre valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst out_pc",    out_pc,         32'd0);
    chk("rst out_instr", out_instr,      32'd0);
    chk("rst out_imm",   out_imm,        32'd0);
    chk("rst out_rd",    32'(out_addr_rd), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'h00500093;
    tick();
    in_valid = 1'b0;
    check_out("post-rst", ref_decode(32'h400, 32'h00500093));
    tick();
    chk("post-rst drain", 32'(out_valid), 32'd0);

    // Randomized traffic against the queue model.
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] r;
      logic [6:0]  ops [6];
      int          sel;
      logic        mready, acc, con;
      ops = '{7'h37, 7'h17, 7'h13, 7'h67, 7'h6F, 7'h33};
      r   = $urandom();
      sel = $urandom_range(0, 8);
      if (sel < 6) begin
        in_instr = {r[31:7], ops[sel]};
        if (sel == 5 && r[0]) in_instr[31:25] = r[1] ? 7'h20 : 7'h00;
        if (sel == 3 && r[0]) in_instr[14:12] = 3'd0;
      end else if (sel == 6) begin
        in_instr = 32'h10500073;
      end else begin
        in_instr = $urandom();
      end
      in_pc     = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      #1;
`ifdef DECODE_SKID_EN
      mready = (q.size() < 2);
`else
      mready = (q.size() == 0) || out_ready;
`endif
      chk("rnd in_ready",  32'(in_ready),  32'(mready));
      chk("rnd out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0 && out_valid) check_out("rnd", q[0]);
      acc = in_valid && mready;
      con = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(ref_decode(in_pc, in_instr));
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
